// File: rtl/controller_data_ram_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between two local masters,
// with a built-in zero-fill sequencer that sweeps every word of the RAM.
module controller_data_ram_arbiter #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [BE_WIDTH-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_writedata,
  input  logic [DATA_WIDTH-1:0] ram_readdata
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;

  localparam state_e                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST    = '1;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;       // 0: m0 preferred, 1: m1 preferred
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  rvalid0_q, rvalid1_q;
  logic                  act0, act1, gnt0, gnt1;

  assign act0 = m0_read | m0_write;
  assign act1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rvalid0_q <= gnt0 & m0_read;
      rvalid1_q <= gnt1 & m1_read;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (act0 && (!act1 || !rr_q)) begin
          gnt0 = 1'b1;
        end else if (act1) begin
          gnt1 = 1'b1;
        end
        if (gnt1) begin
          ram_address    = m1_address;
          ram_byteenable = m1_byteenable;
          ram_writedata  = m1_writedata;
        end
        if (gnt0 || gnt1) begin
          ram_chipselect = 1'b1;
          ram_write      = gnt0 ? m0_write : m1_write;
          rr_d           = gnt0;
        end
        // A grant in the same cycle is still served; the sweep begins next cycle.
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        ram_address    = cnt_q;
        ram_byteenable = '1;
        ram_writedata  = '0;
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        cnt_d          = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign m0_waitrequest   = act0 & ~gnt0;
  assign m1_waitrequest   = act1 & ~gnt1;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rvalid0_q;
  assign m1_readdatavalid = rvalid1_q;
  assign clear_busy       = (state_q == ST_CLEAR);
  assign clear_done       = done_q;

endmodule

// File: tb/tb_controller_data_ram_arbiter.sv
// Directed bench: a transaction-level model of arbitration, read return and
// zero-fill is compared against the DUT every cycle, plus literal expectations.
module tb_controller_data_ram_arbiter;
  localparam int AW = 11, DW = 32, BW = 4, DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          clear_start = 1'b0, clear_busy, clear_done;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write;
  logic [DW-1:0] ram_writedata, ram_readdata;

  controller_data_ram_arbiter #(.CLEAR_ON_RESET(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // Second instance: clear-on-reset variant, requesters idle.
  logic          rst1_n = 1'b0;
  logic [AW-1:0] b_addr_in = '0;
  logic [BW-1:0] b_be_in = '0;
  logic [DW-1:0] b_wd_in = '0, b_ram_readdata = '0;
  logic          b_zero = 1'b0;
  logic          b_w0, b_w1, b_v0, b_v1, b_clear_busy, b_clear_done, b_cs, b_we;
  logic [DW-1:0] b_rd0, b_rd1, b_ram_wd;
  logic [AW-1:0] b_ram_address;
  logic [BW-1:0] b_ram_be;

  controller_data_ram_arbiter #(.CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset_n(rst1_n),
    .m0_address(b_addr_in), .m0_byteenable(b_be_in), .m0_read(b_zero),
    .m0_write(b_zero), .m0_writedata(b_wd_in), .m0_waitrequest(b_w0),
    .m0_readdata(b_rd0), .m0_readdatavalid(b_v0),
    .m1_address(b_addr_in), .m1_byteenable(b_be_in), .m1_read(b_zero),
    .m1_write(b_zero), .m1_writedata(b_wd_in), .m1_waitrequest(b_w1),
    .m1_readdata(b_rd1), .m1_readdatavalid(b_v1),
    .clear_start(b_zero), .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .ram_address(b_ram_address), .ram_byteenable(b_ram_be),
    .ram_chipselect(b_cs), .ram_write(b_we),
    .ram_writedata(b_ram_wd), .ram_readdata(b_ram_readdata)
  );

  // RAM: address registered on clk, q unregistered.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_areg;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      ram_areg <= ram_address;
      if (ram_write)
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = ram_mem[ram_areg];

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, preferred requester, words left to clear,
  // and the read (if any) whose data returns next cycle.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy = 0, m_done = 0, m_vld0 = 0, m_vld1 = 0;
  int            m_idx = 0, m_pref = 0;
  logic [DW-1:0] m_rdata = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_rvalid0", m0_readdatavalid, 0);
      chk("rst_rvalid1", m1_readdatavalid, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      m_busy = 0; m_done = 0; m_vld0 = 0; m_vld1 = 0; m_idx = 0; m_pref = 0;
    end else begin
      bit a0, a1, n_v0, n_v1, n_done, wr;
      int g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] be;
      a0 = m0_read | m0_write;
      a1 = m1_read | m1_write;
      chk("rvalid0", m0_readdatavalid, m_vld0);
      chk("rvalid1", m1_readdatavalid, m_vld1);
      if (m_vld0 || m_vld1) begin
        chk("readdata0", m0_readdata, m_rdata);
        chk("readdata1", m1_readdata, m_rdata);
      end
      chk("busy", clear_busy, m_busy);
      chk("done", clear_done, m_done);
      n_v0 = 0; n_v1 = 0; n_done = 0;
      if (m_busy) begin
        chk("clr_wait0", m0_waitrequest, a0);
        chk("clr_wait1", m1_waitrequest, a1);
        chk("clr_cs", ram_chipselect, 1);
        chk("clr_we", ram_write, 1);
        chk("clr_addr", ram_address, m_idx);
        chk("clr_be", ram_byteenable, 4'hF);
        chk("clr_wdata", ram_writedata, 0);
        m_mem[m_idx] = '0;
        if (m_idx == DEPTH - 1) begin
          m_busy = 0; m_idx = 0; n_done = 1;
        end else m_idx++;
      end else begin
        if (a0 && a1) g = m_pref;
        else if (a0) g = 0;
        else if (a1) g = 1;
        else g = -1;
        chk("wait0", m0_waitrequest, a0 && g != 0);
        chk("wait1", m1_waitrequest, a1 && g != 1);
        chk("cs", ram_chipselect, g >= 0);
        if (g >= 0) begin
          wr = (g == 0) ? m0_write : m1_write;
          a  = (g == 0) ? m0_address : m1_address;
          d  = (g == 0) ? m0_writedata : m1_writedata;
          be = (g == 0) ? m0_byteenable : m1_byteenable;
          chk("we", ram_write, wr);
          chk("addr", ram_address, a);
          if (wr) begin
            chk("be", ram_byteenable, be);
            chk("wdata", ram_writedata, d);
            for (int b = 0; b < BW; b++)
              if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
          end else begin
            if (g == 0) n_v0 = 1; else n_v1 = 1;
            m_rdata = m_mem[a];
          end
          m_pref = (g == 0) ? 1 : 0;
        end else begin
          chk("we_idle", ram_write, 0);
        end
        if (clear_start) begin
          m_busy = 1; m_idx = 0;
        end
      end
      m_vld0 = n_v0; m_vld1 = n_v1; m_done = n_done;
    end
  end

  task automatic drive(input int id, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic xfer(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, output logic [DW-1:0] rd, output int waits);
    @(posedge clk); #1;
    drive(id, !wr, wr, a, d, be);
    waits = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!((id == 0) ? m0_waitrequest : m1_waitrequest)) break;
      waits++;
    end
    if (waits >= 4000) chk("xfer_timeout", 1, 0);
    @(posedge clk); #1;
    drive(id, 0, 0, '0, '0, '0);
    rd = '0;
    if (!wr) begin
      @(negedge clk);
      rd = (id == 0) ? m0_readdata : m1_readdata;
      chk("xfer_own_valid", (id == 0) ? m0_readdatavalid : m1_readdatavalid, 1);
      chk("xfer_other_valid", (id == 0) ? m1_readdatavalid : m0_readdatavalid, 0);
    end
    $display("txn m%0d %s addr=%03h data=%08h be=%h waits=%0d", id, wr ? "WR" : "RD", a,
             wr ? d : rd, be, waits);
  endtask

  // Counts clear_busy/clear_done cycles until busy drops; optionally re-pulses clear_start.
  task automatic watch_clear(input int pulse_at, output int bc, output int dc);
    bit busy_s;
    bc = 0; dc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      busy_s = clear_busy;
      if (busy_s) bc++;
      if (clear_done) dc++;
      @(posedge clk); #1;
      clear_start = (pulse_at > 0 && bc == pulse_at);
      if (bc > 0 && !busy_s) begin
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        break;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    int waits, bc, dc, v0, v1;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'hDEAD0000 ^ 32'(i);
      m_mem[i]   = 32'hDEAD0000 ^ 32'(i);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Contention from reset: m0 first, then strict alternation.
    drive(0, 1, 0, 11'h010, '0, 4'hF);
    drive(1, 1, 0, 11'h020, '0, 4'hF);
    v0 = 0; v1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("cont_wait0", m0_waitrequest, k % 2);
      chk("cont_wait1", m1_waitrequest, (k % 2) == 0);
      v0 += m0_readdatavalid; v1 += m1_readdatavalid;
      @(posedge clk); #1;
    end
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    v0 += m0_readdatavalid; v1 += m1_readdatavalid;
    chk("cont_valids_m0", v0, 4);
    chk("cont_valids_m1", v1, 4);
    $display("txn contention m0_valids=%0d m1_valids=%0d", v0, v1);

    // Single read by m1.
    xfer(1, 1, 11'h005, 32'h12345678, 4'hF, rd, waits);
    xfer(1, 0, 11'h005, '0, 4'hF, rd, waits);
    chk("single_read_wait", waits, 0);
    chk("single_read_data", rd, 32'h12345678);

    // Byte-enable write at the top address.
    xfer(0, 1, 11'h7FF, 32'hFFFFFFFF, 4'hF, rd, waits);
    xfer(0, 1, 11'h7FF, 32'hAABBCCDD, 4'b0101, rd, waits);
    xfer(0, 0, 11'h7FF, '0, 4'hF, rd, waits);
    chk("byte_write_readback", rd, 32'hFFBBFFDD);

    // Full clear with both requesters stalled throughout.
    xfer(0, 1, 11'h000, 32'h11111111, 4'hF, rd, waits);
    xfer(1, 1, 11'h400, 32'h22222222, 4'hF, rd, waits);
    xfer(0, 1, 11'h7FF, 32'h33333333, 4'hF, rd, waits);
    @(posedge clk); #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    drive(0, 1, 0, 11'h040, '0, 4'hF);
    drive(1, 0, 1, 11'h300, 32'h00000055, 4'hF);
    watch_clear(0, bc, dc);
    chk("clear_busy_cycles", bc, 2048);
    chk("clear_done_pulses", dc, 1);
    $display("txn clear busy_cycles=%0d done_pulses=%0d", bc, dc);
    xfer(0, 0, 11'h000, '0, 4'hF, rd, waits);
    chk("clear_rd_000", rd, 0);
    xfer(1, 0, 11'h400, '0, 4'hF, rd, waits);
    chk("clear_rd_400", rd, 0);
    xfer(0, 0, 11'h7FF, '0, 4'hF, rd, waits);
    chk("clear_rd_7ff", rd, 0);

    // clear_start in the same cycle as an accepted read; re-pulse mid-clear.
    xfer(1, 1, 11'h0A5, 32'hCAFEF00D, 4'hF, rd, waits);
    @(posedge clk); #1;
    drive(0, 1, 0, 11'h0A5, '0, 4'hF);
    clear_start = 1'b1;
    @(negedge clk);
    chk("coll_wait0", m0_waitrequest, 0);
    chk("coll_busy_before", clear_busy, 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("coll_valid0", m0_readdatavalid, 1);
    chk("coll_data", m0_readdata, 32'hCAFEF00D);
    chk("coll_busy_first", clear_busy, 1);
    watch_clear(100, bc, dc);
    chk("coll_busy_cycles", bc + 1, 2048);
    chk("coll_done_pulses", dc, 1);
    $display("txn collision busy_cycles=%0d done_pulses=%0d", bc + 1, dc);

    // Reset mid-clear, clear-on-reset disabled.
    @(posedge clk); #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    bc = 0;
    for (int k = 0; k < 600 && bc < 500; k++) begin
      @(negedge clk);
      if (clear_busy) bc++;
    end
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", clear_busy, 0);
    chk("abort_done", clear_done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    dc = 0;
    repeat (20) begin
      @(negedge clk);
      dc += clear_done;
    end
    chk("abort_no_done", dc, 0);
    $display("txn reset_mid_clear clear_on_reset=0 done_pulses=%0d", dc);

    // Clear-on-reset variant: sweep starts at address 0 and restarts after reset.
    @(negedge clk);
    chk("b_busy_in_reset", b_clear_busy, 1);
    @(posedge clk); #1 rst1_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      chk("b_clear_addr", b_ram_address, k);
      dc += b_clear_done;
    end
    @(posedge clk); #2 rst1_n = 1'b0;
    #1;
    chk("b_abort_busy", b_clear_busy, 1);
    chk("b_abort_addr", b_ram_address, 0);
    chk("b_abort_no_done", dc, 0);
    @(posedge clk); #1 rst1_n = 1'b1;
    bc = 0; dc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) chk("b_restart_addr", b_ram_address, 0);
      if (b_clear_busy) bc++;
      if (b_clear_done) dc++;
      if (bc > 0 && !b_clear_busy) break;
    end
    chk("b_busy_cycles", bc, 2048);
    chk("b_done_pulses", dc, 1);
    $display("txn reset_mid_clear clear_on_reset=1 busy_cycles=%0d done_pulses=%0d", bc, dc);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
